// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit half. It accepts a byte on a start strobe and sends it LSB
//   first as: 1 start bit (0), 8 data bits, an optional parity bit, 1 stop bit (1).
//   The frame format matches the one the receiver checks, so the two halves
//   form a loopback pair.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   tx_enable  gates acceptance of new frames (a frame in progress always completes)
//   tx_start   start request, sampled every cycle
//   tx_data    byte to send, sampled only in the accept cycle
//   tx         serial line, idles high (registered)
//   tx_busy    high while a frame is in progress (registered)
//   tx_done    one-cycle pulse when the stop bit ends (registered)
//
// State   | Meaning
// --------+------------------------------------------------------------
// IDLE    | line high; a new frame is accepted on tx_enable && tx_start
// START   | start bit (0) on the line
// DATA    | data bit shift_reg[0] on the line; bit_idx counts 0..7
// PARITY  | parity of the latched byte (present only when PARITY_EN)
// STOP    | stop bit (1); at its end the block returns to IDLE and pulses tx_done

module uart_tx_serializer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic ODD_BIT    = (PARITY_ODD != 0);
  localparam bit   HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       data_latch;
  logic             bit_end;

  // The counter restarts at every bit boundary, so each bit is exactly
  // CLKS_PER_BIT cycles long and no error accumulates across the frame.
  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_latch <= '0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          // Also taken in the tx_done cycle, so back-to-back frames have no gap.
          if (tx_enable && tx_start) begin
            shift_reg  <= tx_data;
            data_latch <= tx_data;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            state      <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tx    <= shift_reg[0];
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              if (HAS_PARITY) begin
                // Parity comes from the latched byte; tx_data may have changed since.
                tx    <= (^data_latch) ^ ODD_BIT;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              // Put the next bit on the line while shifting it into position 0.
              tx        <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 3'd1;
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int CPB = 16;  // 50 MHz / 3.125 MBd

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_enable;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] tx_v, busy_v, done_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 0: even parity, 1: odd parity, 2: no parity
  uart_tx_serializer #(.CLK_FREQ(50000000), .BAUD_RATE(3125000), .PARITY_EN(1), .PARITY_ODD(0))
    u_even (.clk(clk), .reset(reset), .tx_enable(tx_enable), .tx_start(tx_start),
            .tx_data(tx_data), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_serializer #(.CLK_FREQ(50000000), .BAUD_RATE(3125000), .PARITY_EN(1), .PARITY_ODD(1))
    u_odd (.clk(clk), .reset(reset), .tx_enable(tx_enable), .tx_start(tx_start),
           .tx_data(tx_data), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_serializer #(.CLK_FREQ(50000000), .BAUD_RATE(3125000), .PARITY_EN(0), .PARITY_ODD(0))
    u_nopar (.clk(clk), .reset(reset), .tx_enable(tx_enable), .tx_start(tx_start),
             .tx_data(tx_data), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

  typedef struct {
    logic [7:0]  data;
    logic [10:0] exp;    // line bits in time order: [0]=start ... last=stop
    int          nbits;
    int          sel;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line must stay idle (tx=1, busy=0, no done) for ncyc cycles.
  task automatic idle_check(input string name, input int sel, input int ncyc);
    int bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (tx_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 || done_v[sel] !== 1'b0) bad++;
      @(negedge clk);
    end
    check(name, bad, 0);
  endtask

  // Called at the negedge of cycle 0 (just after the accept edge). Checks every
  // cycle of every bit, then the done cycle. Returns at the done cycle.
  // mode 1 injects a start pulse + data change mid-frame and drops tx_enable at data bit 4.
  task automatic frame_check(input string name, input logic [10:0] exp, input int nbits,
                             input int sel, input int mode);
    for (int b = 0; b < nbits; b++) begin
      int bad = 0;
      for (int k = 0; k < CPB; k++) begin
        int c = b * CPB + k;
        if (tx_v[sel] !== exp[b] || busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0) bad++;
        if (mode == 1) begin
          if (c == 40) begin tx_start = 1'b1; tx_data = 8'hFF; end
          if (c == 41) tx_start = 1'b0;
          if (c == 80) tx_enable = 1'b0;
        end
        @(negedge clk);
      end
      check($sformatf("%s bit%0d", name, b), bad, 0);
    end
    check($sformatf("%s done", name), done_v[sel], 1);
    check($sformatf("%s busy_low", name), busy_v[sel], 0);
    check($sformatf("%s tx_idle", name), tx_v[sel], 1);
  endtask

  task automatic start_frame(input logic [7:0] d);
    tx_data   = d;
    tx_start  = 1'b1;
    tx_enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    tx_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h55, {1'b1, 1'b0, 8'h55, 1'b0}, 11, 0, "even_55"};
    vecs[1] = '{8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, 11, 0, "even_00"};
    vecs[2] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 11, 0, "even_FF"};
    vecs[3] = '{8'h01, {1'b1, 1'b1, 8'h01, 1'b0}, 11, 0, "even_01"};
    vecs[4] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}, 11, 0, "even_80"};
    vecs[5] = '{8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 0, "even_07"};
    vecs[6] = '{8'h07, {1'b1, 1'b0, 8'h07, 1'b0}, 11, 1, "odd_07"};
    vecs[7] = '{8'h2D, {1'b1, 1'b1, 8'h2D, 1'b0}, 11, 1, "odd_2D"};
    vecs[8] = '{8'h07, {1'b0, 1'b1, 8'h07, 1'b0}, 10, 2, "nopar_07"};

    // Reset held 3 cycles with tx_start high: must stay idle.
    reset = 1'b1; tx_enable = 1'b1; tx_start = 1'b1; tx_data = 8'h55;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d tx", i), tx_v[0], 1);
      check($sformatf("rst%0d busy", i), busy_v[0], 0);
      check($sformatf("rst%0d done", i), done_v[0], 0);
      if (i == 2) reset = 1'b0;
      @(negedge clk);
    end
    // First edge after release accepts.
    tx_start = 1'b0;
    frame_check("rst_then_55", {1'b1, 1'b0, 8'h55, 1'b0}, 11, 0, 0);
    @(negedge clk);
    check("after_done tx", tx_v[0], 1);
    check("after_done done_clear", done_v[0], 0);
    repeat (CPB) @(negedge clk);

    // Table-driven frames.
    foreach (vecs[i]) begin
      start_frame(vecs[i].data);
      tx_start = 1'b0;
      frame_check(vecs[i].name, vecs[i].exp, vecs[i].nbits, vecs[i].sel, 0);
      repeat (CPB + 1) @(negedge clk);
    end

    // Back-to-back with tx_start held through the done cycle.
    do_reset();
    start_frame(8'hA3);
    tx_data = 8'h3C;
    frame_check("b2b_A3", {1'b1, 1'b0, 8'hA3, 1'b0}, 11, 0, 0);
    @(negedge clk);
    tx_start = 1'b0;
    frame_check("b2b_3C", {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 0, 0);
    @(negedge clk);

    // Mid-frame start/data change and tx_enable drop; then blocked start.
    do_reset();
    start_frame(8'h96);
    tx_start = 1'b0;
    frame_check("middist_96", {1'b1, 1'b0, 8'h96, 1'b0}, 11, 0, 1);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h11;
    idle_check("blocked_when_disabled", 0, 20);
    tx_enable = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    frame_check("reenable_11", {1'b1, 1'b0, 8'h11, 1'b0}, 11, 0, 0);
    @(negedge clk);

    // Reset during data bit 2 aborts the frame without a done pulse.
    do_reset();
    start_frame(8'h00);
    tx_start = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_abort tx", tx_v[0], 0);
    check("pre_abort busy", busy_v[0], 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort tx", tx_v[0], 1);
    check("abort busy", busy_v[0], 0);
    check("abort done", done_v[0], 0);
    reset = 1'b0;
    @(negedge clk);
    idle_check("post_abort_idle", 0, 30);
    start_frame(8'hC9);
    tx_start = 1'b0;
    frame_check("fresh_C9", {1'b1, 1'b0, 8'hC9, 1'b0}, 11, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
